// File: rtl/seven_seg_digit_driver.sv
// 4-digit hex 7-segment cathode driver slaved to an external anode scanner.
// Latency: anode -> an_out/seg/dp is SYNC_STAGES+1 cycles; a loaded value shows from the next frame start.
// Backpressure: in_ready drops after an accept and rises the cycle after the frame start that commits it.
module seven_seg_digit_driver #(
  parameter int BLANK_LZ     = 1,
  parameter int BLINK_FRAMES = 64,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic [3:0]  in_dp,
  input  logic        in_blink,
  output logic [3:0]  an_out,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int            CW       = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [3:0]    AN_D0    = 4'b1110;
  localparam logic [3:0]    AN_OFF   = 4'b1111;
  localparam logic [6:0]    SEG_OFF  = 7'h7F;

  logic [3:0]    sync_q [SYNC_STAGES];
  logic [3:0]    a_s;
  logic [3:0]    a_s_prev;
  logic          fs;

  logic          pend_full;
  logic [15:0]   pend_dat;
  logic [3:0]    pend_dp;
  logic          pend_blink;

  logic [15:0]   disp_dat;
  logic [3:0]    disp_dp;
  logic          disp_blink;
  logic [CW-1:0] frame_cnt;
  logic          phase_on;

  logic          accept;
  logic          commit;
  logic [15:0]   disp_dat_nxt;
  logic [3:0]    disp_dp_nxt;
  logic          disp_blink_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          phase_nxt;

  logic          dig_vld;
  logic [1:0]    dig_idx;
  logic [3:0]    nib;
  logic [3:0]    lz;
  logic          blank;

  // Active-low cathode pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  assign a_s      = sync_q[SYNC_STAGES-1];
  assign fs       = (a_s == AN_D0) && (a_s_prev != AN_D0);
  assign in_ready = ~pend_full;
  assign accept   = in_valid & in_ready;
  assign commit   = fs & pend_full;

  // Bring the scanner anode into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= AN_OFF;
    end else begin
      sync_q[0] <= anode;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Display contents as they will be after this edge; decoding from these
  // makes a committing frame start show the new value on digit 0 as well.
  always_comb begin
    disp_dat_nxt   = commit ? pend_dat   : disp_dat;
    disp_dp_nxt    = commit ? pend_dp    : disp_dp;
    disp_blink_nxt = commit ? pend_blink : disp_blink;
  end

  // Blink phase: count frames while blinking, flip phase every BLINK_FRAMES frames.
  always_comb begin
    cnt_nxt   = frame_cnt;
    phase_nxt = phase_on;
    if (commit || !disp_blink) begin
      cnt_nxt   = '0;
      phase_nxt = 1'b1;
    end else if (fs) begin
      if (frame_cnt == CNT_LAST) begin
        cnt_nxt   = '0;
        phase_nxt = ~phase_on;
      end else begin
        cnt_nxt = frame_cnt + 1'b1;
      end
    end
  end

  // Which digit the synchronised anode selects, its nibble and whether it is a leading zero.
  always_comb begin
    dig_vld = 1'b1;
    dig_idx = 2'd0;
    case (a_s)
      4'b1110: dig_idx = 2'd0;
      4'b1101: dig_idx = 2'd1;
      4'b1011: dig_idx = 2'd2;
      4'b0111: dig_idx = 2'd3;
      default: dig_vld = 1'b0;
    endcase
    nib   = disp_dat_nxt[{dig_idx, 2'b00} +: 4];
    lz[3] = (disp_dat_nxt[15:12] == 4'h0);
    lz[2] = lz[3] && (disp_dat_nxt[11:8] == 4'h0);
    lz[1] = lz[2] && (disp_dat_nxt[7:4] == 4'h0);
    lz[0] = 1'b0;
    blank = (BLANK_LZ != 0) && lz[dig_idx];
  end

  // Pending buffer, displayed buffer and blink state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_s_prev   <= AN_OFF;
      pend_full  <= 1'b0;
      pend_dat   <= '0;
      pend_dp    <= '0;
      pend_blink <= 1'b0;
      disp_dat   <= '0;
      disp_dp    <= '0;
      disp_blink <= 1'b0;
      frame_cnt  <= '0;
      phase_on   <= 1'b1;
    end else begin
      a_s_prev   <= a_s;
      disp_dat   <= disp_dat_nxt;
      disp_dp    <= disp_dp_nxt;
      disp_blink <= disp_blink_nxt;
      frame_cnt  <= cnt_nxt;
      phase_on   <= phase_nxt;
      if (commit) begin
        pend_full <= 1'b0;
      end else if (accept) begin
        pend_full  <= 1'b1;
        pend_dat   <= in_data;
        pend_dp    <= in_dp;
        pend_blink <= in_blink;
      end
    end
  end

  // Registered pin outputs; an_out, seg and dp always change together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_out <= AN_OFF;
      seg    <= SEG_OFF;
      dp     <= 1'b1;
    end else if (!dig_vld) begin
      an_out <= AN_OFF;
      seg    <= SEG_OFF;
      dp     <= 1'b1;
    end else begin
      an_out <= a_s;
      if (!phase_nxt) begin
        seg <= SEG_OFF;
        dp  <= 1'b1;
      end else begin
        seg <= blank ? SEG_OFF : seg_decode(nib);
        dp  <= ~disp_dp_nxt[dig_idx];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Randomised scoreboard bench for seven_seg_digit_driver (SYNC_STAGES=2, BLINK_FRAMES=2).
// A frame-level reference model pushes the expected pin state for every cycle;
// a separate monitor pops and compares at each falling edge.
module tb_seven_seg_digit_driver;
  localparam int SS    = 2;
  localparam int BF    = 2;
  localparam int DWELL = 3;
  localparam int FRAME = 4 * DWELL;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  anode = 4'hF;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_dp = '0;
  logic        in_blink = 1'b0;
  logic [3:0]  an_out;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[$];

  // stimulus-side scanner state
  int         scan_pos = 0;
  bit         force_en = 0;
  logic [3:0] force_an = 4'hF;

  // reference model state
  logic [3:0]  m_sync [SS];
  logic [3:0]  m_prev;
  bit          m_pfull;
  logic [15:0] m_pdat;
  logic [3:0]  m_pdp;
  bit          m_pblink;
  logic [15:0] m_dat;
  logic [3:0]  m_ddp;
  bit          m_dblink;
  int          m_frames;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seven_seg_digit_driver #(
    .BLANK_LZ    (1),
    .BLINK_FRAMES(BF),
    .SYNC_STAGES (SS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .anode   (anode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data (in_data),
    .in_dp   (in_dp),
    .in_blink(in_blink),
    .an_out  (an_out),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 clk = ~clk;

  function automatic exp_t reset_item();
    exp_t e;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.rdy = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SS; i++) m_sync[i] = 4'hF;
    m_prev   = 4'hF;
    m_pfull  = 0;
    m_pdat   = '0;
    m_pdp    = '0;
    m_pblink = 0;
    m_dat    = '0;
    m_ddp    = '0;
    m_dblink = 0;
    m_frames = 0;
  endtask

  // Predict the pin state after the coming rising edge from the inputs now applied.
  task automatic model_step();
    logic [3:0] as;
    logic [3:0] oh;
    logic [3:0] nib;
    bit         fs;
    bit         on;
    int         k;
    exp_t       e;
    as = m_sync[SS-1];
    fs = (as == 4'b1110) && (m_prev != 4'b1110);
    if (fs && m_pfull) begin
      m_dat    = m_pdat;
      m_ddp    = m_pdp;
      m_dblink = m_pblink;
      m_frames = 0;
      m_pfull  = 0;
    end else if (in_valid && !m_pfull) begin
      m_pdat   = in_data;
      m_pdp    = in_dp;
      m_pblink = in_blink;
      m_pfull  = 1;
      if (fs) m_frames++;
    end else if (fs) begin
      m_frames++;
    end
    on = !m_dblink || ((m_frames / BF) % 2 == 0);
    e = reset_item();
    e.rdy = !m_pfull;
    k = -1;
    for (int i = 0; i < 4; i++) begin
      oh = 4'b0001 << i;
      if (as == ~oh) k = i;
    end
    if (k >= 0) begin
      e.an = as;
      if (on) begin
        nib = 4'(m_dat >> (4 * k));
        if (k > 0 && (m_dat >> (4 * k)) == 16'h0) e.seg = 7'h7F;
        else e.seg = seg_tbl[nib];
        e.dp = !m_ddp[k];
      end
    end
    for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = anode;
    m_prev = as;
    exp_q.push_back(e);
  endtask

  // reference model process
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        model_reset();
        exp_q.delete();
        exp_q.push_back(reset_item());
      end else begin
        model_step();
      end
    end
  end

  // monitor process
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL scoreboard_empty t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          if ({an_out, seg, dp, in_ready} !== e) begin
            n_bad++;
            $display("FAIL pins t=%0t got an=%b seg=%h dp=%b rdy=%b want an=%b seg=%h dp=%b rdy=%b",
                     $time, an_out, seg, dp, in_ready, e.an, e.seg, e.dp, e.rdy);
          end
        end
      end
    end
  end

  // one clock of scanner activity; inputs change just after the rising edge
  task automatic tick();
    logic [3:0] oh;
    @(posedge clk);
    #1;
    scan_pos = (scan_pos + 1) % FRAME;
    oh = 4'b0001 << (scan_pos / DWELL);
    anode = force_en ? force_an : ~oh;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // hold in_valid until accepted; leaves in_valid high with the accepted data
  task automatic offer(input logic [15:0] d, input logic [3:0] p, input logic b);
    bit acc;
    int n;
    in_data  = d;
    in_dp    = p;
    in_blink = b;
    in_valid = 1'b1;
    n = 0;
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout got in_ready=%b want 1 within 200 cycles", in_ready);
    end
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p, input logic b);
    offer(d, p, b);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({an_out, seg, dp, in_ready} !== reset_item()) begin
      n_bad++;
      $display("FAIL reset_immediate got an=%b seg=%h dp=%b rdy=%b want an=1111 seg=7f dp=1 rdy=1",
               an_out, seg, dp, in_ready);
    end
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    run(4 * FRAME);

    run(5);
    load(16'h12AF, 4'b0100, 1'b0);
    run(3 * FRAME);

    run(4);
    offer(16'h0001, 4'b0000, 1'b0);
    load(16'h0002, 4'b0000, 1'b0);
    run(3 * FRAME);

    load(16'h0300, 4'b0000, 1'b0);
    run(2 * FRAME);
    load(16'h0000, 4'b1000, 1'b0);
    run(2 * FRAME);

    load(16'hBEEF, 4'b0011, 1'b1);
    run(10 * FRAME);

    force_en = 1;
    force_an = 4'b1111;
    run(6);
    force_an = 4'b1100;
    run(6);
    force_en = 0;
    run(2 * FRAME);

    load(16'hC0DE, 4'b0001, 1'b1);
    run(5 * FRAME + 2);
    load(16'h4567, 4'b1111, 1'b0);
    do_reset();
    run(3 * FRAME);

    for (int r = 0; r < 80; r++) begin
      run($urandom_range(0, 2 * FRAME));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: load(16'($urandom), 4'($urandom), 1'($urandom_range(0, 3) == 0));
        4: load(16'($urandom_range(0, 255)), 4'($urandom), 1'b0);
        5, 6: begin
          in_data  = 16'($urandom);
          in_dp    = 4'($urandom);
          in_blink = 1'($urandom);
          in_valid = 1'b1;
          tick();
          in_valid = 1'b0;
        end
        7: begin
          force_en = 1;
          force_an = 4'($urandom);
          run($urandom_range(1, 5));
          force_en = 0;
        end
        8: run(3 * FRAME);
        default: if ($urandom_range(0, 3) == 0) do_reset();
      endcase
    end
    run(2 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
